// File: rtl/imem_boot_loader.sv
// Boot loader: streams words into instruction SRAM, verifies a checksum,
// then releases the CPU from reset after a programmable delay.
module imem_boot_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 1024,
  parameter int CNT_W       = 11,
  parameter int BASE_ADDR   = 1,
  parameter int ADDR_STEP   = 1,
  parameter int RELEASE_DLY = 2,
  parameter int CHECK_EN    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [CNT_W-1:0]  load_len,
  input  logic [31:0]       exp_sum,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              cpu_reset,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DELAY,
    S_RUN,
    S_ERROR
  } state_t;

  localparam int DLY_W =
    (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST =
    DLY_W'((RELEASE_DLY > 0) ? RELEASE_DLY - 1 : 0);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [CNT_W-1:0]  MAX_LEN = CNT_W'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       exp_q;
  logic [DLY_W-1:0]  dly;

  logic              beat;
  logic              len_ok;
  logic              sum_ok;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [31:0]       beat_word;

  // Checksum always runs over the low 32 bits, zero-extended if narrower
  assign beat_word = 32'(s_data);
  assign s_ready   = (state == S_LOAD);
  assign beat      = s_valid && s_ready;
  assign cnt_nxt   = cnt + CNT_W'(1);
  assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
  assign sum_ok    = (CHECK_EN == 0) || (sum == exp_q);

  assign busy = (state == S_LOAD) || (state == S_CHECK) ||
                (state == S_DELAY);
  assign done = (state == S_RUN);
  assign err  = (state == S_ERROR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      exp_q      <= '0;
      dly        <= '0;
      sum        <= '0;
      sram_wen   <= 1'b0;
      sram_waddr <= BASE;
      sram_wdata <= '0;
      cpu_reset  <= 1'b1;
      fetch_en   <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            len_q     <= load_len;
            exp_q     <= exp_sum;
            cnt       <= '0;
            sum       <= '0;
            cpu_reset <= 1'b1;
            fetch_en  <= 1'b0;
            state     <= len_ok ? S_LOAD : S_ERROR;
          end
        end
        S_LOAD: begin
          if (beat) begin
            sram_wen   <= 1'b1;
            sram_waddr <= BASE + ADDR_W'(cnt) * STEP;
            sram_wdata <= s_data;
            sum        <= sum + beat_word;
            cnt        <= cnt_nxt;
          end
          // abort wins over completion; the beat above still lands
          if (abort)
            state <= S_ERROR;
          else if (beat && cnt_nxt == len_q)
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (abort || !sum_ok) begin
            state <= S_ERROR;
          end else if (RELEASE_DLY == 0) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            fetch_en  <= 1'b1;
          end else begin
            state <= S_DELAY;
            dly   <= '0;
          end
        end
        S_DELAY: begin
          if (abort) begin
            state <= S_ERROR;
          end else if (dly == DLY_LAST) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            fetch_en  <= 1'b1;
          end else begin
            dly <= dly + DLY_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
